sa_inst_issuer: RTL and testbench

Instruction queue and issue sequencer that sits directly upstream of the systolic-array top. It buffers host-written instructions in a FIFO and issues them one at a time over the array's init_inst_pulse/instruction interface. For each instruction it holds init_inst_pulse high until idle_flag falls, then waits for flag before issuing the next one. This lets software push whole instruction batches (AXI_TO_UB, MAT_MUL, ACC_TO_UB, ...) without per-instruction polling.

---
 rtl/sa_inst_issuer.sv | 179 +++++++++++++++++
 tb/tb_sa_inst_issuer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_inst_issuer.sv
// sa_inst_issuer: instruction FIFO plus issue sequencer placed in front of the systolic array.
// Queued words are issued in order over the init_inst_pulse / idle_flag / flag handshake.
module sa_inst_issuer #(
  parameter int INST_BITS      = 64,
  parameter int DEPTH          = 16,
  parameter int OPCODE_LSB     = 60,
  parameter int OPCODE_BITS    = 4,
  parameter int IDLE_OPCODE    = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [INST_BITS-1:0]   push_inst,
  input  logic                   run_en,
  input  logic                   flush,
  output logic                   init_inst_pulse,
  output logic [INST_BITS-1:0]   instruction,
  input  logic                   idle_flag,
  input  logic                   flag,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [15:0]            issued_cnt,
  output logic                   timeout_err,
  input  logic                   err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t                 state_r;
  logic [INST_BITS-1:0]   mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          count_next_s;
  logic                   push_ready_r;
  logic [INST_BITS-1:0]   instruction_r;
  logic                   pulse_r;
  logic                   busy_r;
  logic [15:0]            issued_r;
  logic [WW-1:0]          wait_cnt_r;
  logic                   timeout_err_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   is_idle_op_s;
  logic                   timeout_hit_s;

  assign push_ready      = push_ready_r;
  assign fifo_count      = count_r;
  assign init_inst_pulse = pulse_r;
  assign instruction     = instruction_r;
  assign busy            = busy_r;
  assign issued_cnt      = issued_r;
  assign timeout_err     = timeout_err_r;

  // Push/pop decode and next occupancy; flush wins over a same-cycle push.
  always_comb begin
    push_s        = push_valid && push_ready_r && !flush;
    pop_s         = (state_r == S_IDLE) && run_en && (count_r != {CW{1'b0}});
    is_idle_op_s  = (instruction_r[OPCODE_LSB +: OPCODE_BITS] == OPCODE_BITS'(IDLE_OPCODE));
    timeout_hit_s = (wait_cnt_r == WAIT_LAST) &&
                    (((state_r == S_WAIT_BUSY) && idle_flag) ||
                     ((state_r == S_WAIT_DONE) && !flag));
    count_next_s  = count_r;
    if (flush) begin
      count_next_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_inst;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      push_ready_r <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r      <= count_next_s;
      push_ready_r <= (count_next_s != FULL_COUNT);
    end
  end

  // Issue sequencer with registered handshake outputs and wait-state watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      instruction_r <= {INST_BITS{1'b0}};
      pulse_r       <= 1'b0;
      busy_r        <= 1'b0;
      issued_r      <= 16'd0;
      wait_cnt_r    <= {WW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else if (err_clr) begin
        timeout_err_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            instruction_r <= mem_r[rd_ptr_r];
            pulse_r       <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_r <= {WW{1'b0}};
          if (is_idle_op_s) begin
            pulse_r  <= 1'b0;
            busy_r   <= 1'b0;
            issued_r <= issued_r + 16'd1;
            state_r  <= S_IDLE;
          end else begin
            state_r <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!idle_flag) begin
            pulse_r    <= 1'b0;
            wait_cnt_r <= {WW{1'b0}};
            state_r    <= S_WAIT_DONE;
          end else if (timeout_hit_s) begin
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        S_WAIT_DONE: begin
          // Only reached after idle_flag fell, so any flag seen here belongs to this instruction.
          if (flag) begin
            issued_r <= issued_r + 16'd1;
            busy_r   <= 1'b0;
            state_r  <= S_IDLE;
          end else if (timeout_hit_s) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        default: begin
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sa_inst_issuer.sv
// Randomized self-checking bench for sa_inst_issuer with a simple array responder
// and a queue-based model of the expected issue order.
`timescale 1ns/1ps
module tb_sa_inst_issuer;
  localparam int IB    = 64;
  localparam int DEPTH = 16;
  localparam int TO    = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid;
  logic          push_ready;
  logic [IB-1:0] push_inst;
  logic          run_en;
  logic          flush;
  logic          init_inst_pulse;
  logic [IB-1:0] instruction;
  logic          idle_flag;
  logic          flag;
  logic [4:0]    fifo_count;
  logic          busy;
  logic [15:0]   issued_cnt;
  logic          timeout_err;
  logic          err_clr;

  logic          hang;
  logic [IB-1:0] model_q[$];
  int            checks = 0;
  int            failures = 0;
  int            exp_issued = 0;
  logic          mon_prev_p;
  logic          mon_idle_op;
  logic          mon_hang;
  int            mon_len;

  sa_inst_issuer #(
    .INST_BITS(IB), .DEPTH(DEPTH), .OPCODE_LSB(60), .OPCODE_BITS(4),
    .IDLE_OPCODE(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
    .push_inst(push_inst), .run_en(run_en), .flush(flush),
    .init_inst_pulse(init_inst_pulse), .instruction(instruction),
    .idle_flag(idle_flag), .flag(flag), .fifo_count(fifo_count), .busy(busy),
    .issued_cnt(issued_cnt), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IB-1:0] rand_inst(input logic [3:0] op);
    logic [IB-1:0] w;
    w = {$urandom(), $urandom()};
    w[63:60] = op;
    return w;
  endfunction

  // Called at a negedge; holds push_valid for one clock and mirrors acceptance in the model.
  task automatic push_word(input logic [IB-1:0] w);
    push_valid = 1'b1;
    push_inst  = w;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((busy || fifo_count != 5'd0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < bound), 64'd1);
  endtask

  // Array responder: idle_flag drops 3 cycles into a non-IDLE pulse, flag follows 20 cycles later.
  initial begin
    idle_flag = 1'b1;
    flag      = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && !hang && init_inst_pulse && instruction[63:60] != 4'h0) begin
        repeat (2) @(negedge clk);
        idle_flag = 1'b0;
        repeat (20) @(negedge clk);
        idle_flag = 1'b1;
        flag      = 1'b1;
        @(negedge clk);
        flag = 1'b0;
      end
    end
  end

  // Issue monitor: order, pulse length and pulse release after idle_flag falls.
  initial begin
    logic [IB-1:0] e;
    mon_prev_p = 1'b0;
    mon_len    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mon_prev_p = 1'b0;
        mon_len    = 0;
      end else begin
        if (mon_prev_p && !idle_flag) chk("pulse_release", 64'(init_inst_pulse), 64'd0);
        if (init_inst_pulse && !mon_prev_p) begin
          e = (model_q.size() > 0) ? model_q.pop_front() : {IB{1'bx}};
          chk("issue_order", instruction, e);
          mon_idle_op = (instruction[63:60] == 4'h0);
          mon_hang    = hang;
          mon_len     = 1;
        end else if (init_inst_pulse) begin
          mon_len++;
        end
        if (!init_inst_pulse && mon_prev_p) begin
          if (mon_idle_op)   chk("idle_op_pulse_len", 64'(mon_len), 64'd1);
          else if (mon_hang) chk("timeout_pulse_len", 64'(mon_len >= TO && mon_len <= TO + 1), 64'd1);
        end
        mon_prev_p = init_inst_pulse;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; push_valid = 1'b0; push_inst = '0; run_en = 1'b0;
    flush = 1'b0; err_clr = 1'b0; hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse", 64'(init_inst_pulse), 64'd0);
    chk("rst_inst", instruction, 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_issued", 64'(issued_cnt), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    chk("rst_ready", 64'(push_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Fill to capacity while stalled, overflow push dropped, then drain in order.
    push_word(rand_inst(4'h1));
    for (int i = 1; i < DEPTH; i++) push_word(rand_inst(4'($urandom_range(1, 15))));
    chk("full_count", 64'(fifo_count), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    push_word(rand_inst(4'h2));
    chk("overflow_count", 64'(fifo_count), 64'd16);
    run_en = 1'b1;
    wait_drain(2000);
    exp_issued += 16;
    chk("fill_issued", 64'(issued_cnt), 64'(exp_issued));

    // Five instructions pushed while running.
    for (int i = 0; i < 5; i++) push_word(rand_inst(4'($urandom_range(1, 15))));
    wait_drain(1000);
    exp_issued += 5;
    chk("run5_issued", 64'(issued_cnt), 64'(exp_issued));

    // IDLE opcode sandwiched between two real instructions.
    run_en = 1'b0;
    push_word(rand_inst(4'h3));
    push_word(rand_inst(4'h0));
    push_word(rand_inst(4'h3));
    run_en = 1'b1;
    wait_drain(1000);
    exp_issued += 3;
    chk("idle_op_issued", 64'(issued_cnt), 64'(exp_issued));

    // Array never answers: first entry times out, second completes normally.
    hang = 1'b1;
    run_en = 1'b0;
    push_word(rand_inst(4'h4));
    push_word(rand_inst(4'h5));
    run_en = 1'b1;
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_seen", 64'(timeout_err), 64'd1);
    chk("to_pulse_low", 64'(init_inst_pulse), 64'd0);
    chk("to_not_counted", 64'(issued_cnt), 64'(exp_issued));
    hang = 1'b0;
    wait_drain(1000);
    exp_issued += 1;
    chk("to_next_issued", 64'(issued_cnt), 64'(exp_issued));
    chk("to_sticky", 64'(timeout_err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_cleared", 64'(timeout_err), 64'd0);

    // Flush with a same-cycle push while one instruction is in flight.
    run_en = 1'b0;
    for (int i = 0; i < 5; i++) push_word(rand_inst(4'($urandom_range(1, 15))));
    run_en = 1'b1;
    @(negedge clk);
    run_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("preflush_count", 64'(fifo_count), 64'd4);
    chk("preflush_busy", 64'(busy), 64'd1);
    push_valid = 1'b1;
    push_inst  = rand_inst(4'h6);
    flush      = 1'b1;
    model_q.delete();
    @(negedge clk);
    push_valid = 1'b0;
    flush      = 1'b0;
    chk("flush_count", 64'(fifo_count), 64'd0);
    chk("flush_ready", 64'(push_ready), 64'd1);
    wait_drain(1000);
    exp_issued += 1;
    chk("flush_inflight_done", 64'(issued_cnt), 64'(exp_issued));

    // Asynchronous reset while waiting on idle_flag with three entries queued.
    hang = 1'b1;
    for (int i = 0; i < 4; i++) push_word(rand_inst(4'($urandom_range(1, 15))));
    run_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_pulse", 64'(init_inst_pulse), 64'd1);
    chk("mid_count", 64'(fifo_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_pulse", 64'(init_inst_pulse), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(push_ready), 64'd1);
    chk("arst_issued", 64'(issued_cnt), 64'd0);
    model_q.delete();
    exp_issued = 0;
    @(negedge clk);
    reset = 1'b0;
    hang  = 1'b0;
    @(negedge clk);
    chk("post_arst_pulse", 64'(init_inst_pulse), 64'd0);
    chk("post_arst_count", 64'(fifo_count), 64'd0);
    push_word(rand_inst(4'h7));
    push_word(rand_inst(4'h8));
    wait_drain(1000);
    exp_issued += 2;
    chk("post_arst_issued", 64'(issued_cnt), 64'(exp_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
